// File: rtl/timer_sched.sv
// timer_sched: multi-channel compare timers behind a shared prescaler,
// with latched match events arbitrated onto one fixed-priority interrupt.

// One compare timer channel: CMP/CNT/CCTL plus its tick-driven update.
module timer_chan (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        we_cmp,
  input  logic        we_cnt,
  input  logic        we_cctl,
  input  logic [31:0] wdata,
  output logic [31:0] cmp,
  output logic [31:0] cnt,
  output logic        en,
  output logic        ar,
  output logic        ie,
  output logic        hit
);
  logic upd;

  // A bus write to CNT or CCTL takes the whole channel for that cycle, so the
  // tick is ignored, including its match event.
  assign upd = tick & en & ~we_cnt & ~we_cctl;
  assign hit = upd & (cnt == cmp);

  // Compare value
  always_ff @(posedge clk) begin
    if (rst)         cmp <= '0;
    else if (we_cmp) cmp <= wdata;
  end

  // Counter: bus write, else reload on match (AR), hold on one-shot match, else count
  always_ff @(posedge clk) begin
    if (rst)         cnt <= '0;
    else if (we_cnt) cnt <= wdata;
    else if (upd) begin
      if (cnt == cmp) begin
        if (ar) cnt <= '0;
      end else begin
        cnt <= cnt + 32'd1;
      end
    end
  end

  // Channel control; a one-shot match disarms the channel
  always_ff @(posedge clk) begin
    if (rst)            {ie, ar, en} <= 3'b000;
    else if (we_cctl)   {ie, ar, en} <= wdata[2:0];
    else if (hit && !ar) en <= 1'b0;
  end
endmodule

module timer_sched #(
  parameter int NCH     = 4,
  parameter int PRESC_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic        re,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq,
  output logic [3:0]  irq_id
);
  logic                    gen;
  logic [PRESC_W-1:0]      presc;
  logic [PRESC_W-1:0]      pcnt;
  logic                    tick;
  logic [NCH-1:0]          pend;
  logic [NCH-1:0]          hit;
  logic [NCH-1:0]          en;
  logic [NCH-1:0]          ar;
  logic [NCH-1:0]          ie;
  logic [NCH-1:0]          csel;
  logic [NCH-1:0]          w1c;
  logic [NCH-1:0]          masked;
  logic [NCH-1:0][31:0]    cmp;
  logic [NCH-1:0][31:0]    cnt;
  logic [31:0]             rd;
  logic [3:0]              id_nxt;
  logic                    glob;
  logic [1:0]              sub;
  logic                    unused_addr;

  assign glob        = (addr[7:4] == 4'd0);
  assign sub         = addr[3:2];
  assign unused_addr = ^addr[1:0];

  // Prescaler: tick on terminal count; a smaller PRESC written mid-count
  // lets the count run through the wrap before the next tick.
  assign tick = gen && (pcnt == presc);

  // Prescaler counter, held at zero while globally disabled
  always_ff @(posedge clk) begin
    if (rst || !gen) pcnt <= '0;
    else if (tick)   pcnt <= '0;
    else             pcnt <= pcnt + PRESC_W'(1);
  end

  // Global CTRL / PRESC registers
  always_ff @(posedge clk) begin
    if (rst) begin
      gen   <= 1'b0;
      presc <= '0;
    end else if (we && glob) begin
      if (sub == 2'd0) gen   <= wdata[0];
      if (sub == 2'd1) presc <= wdata[PRESC_W-1:0];
    end
  end

  assign w1c = (we && glob && sub == 2'd2) ? wdata[NCH-1:0] : '0;

  // Pending bits: W1C, with a same-cycle match taking precedence
  always_ff @(posedge clk) begin
    if (rst) pend <= '0;
    else     pend <= (pend & ~w1c) | hit;
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    assign csel[c] = (addr[7:4] == 4'(c + 1));
    timer_chan u_ch (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .we_cmp  (we && csel[c] && sub == 2'd0),
      .we_cnt  (we && csel[c] && sub == 2'd1),
      .we_cctl (we && csel[c] && sub == 2'd2),
      .wdata   (wdata),
      .cmp     (cmp[c]),
      .cnt     (cnt[c]),
      .en      (en[c]),
      .ar      (ar[c]),
      .ie      (ie[c]),
      .hit     (hit[c])
    );
  end

  // Read mux over pre-write state; unmapped space reads zero
  always_comb begin
    rd = '0;
    if (glob) begin
      case (sub)
        2'd0:    rd = {31'b0, gen};
        2'd1:    rd = 32'(presc);
        2'd2:    rd = 32'(pend);
        default: rd = 32'(irq_id);
      endcase
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (csel[c]) begin
          case (sub)
            2'd0:    rd = cmp[c];
            2'd1:    rd = cnt[c];
            2'd2:    rd = {29'b0, ie[c], ar[c], en[c]};
            default: rd = '0;
          endcase
        end
      end
    end
  end

  // Registered read port, one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= rd;
    end
  end

  // Priority encode enabled pending bits, lowest channel wins
  always_comb begin
    masked = pend & ie;
    id_nxt = 4'd0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (masked[c]) id_nxt = 4'(c + 1);
    end
  end

  // Registered interrupt outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      irq    <= 1'b0;
      irq_id <= 4'd0;
    end else begin
      irq    <= |masked;
      irq_id <= id_nxt;
    end
  end
endmodule

// File: tb/tb_timer_sched.sv
// Directed bench for timer_sched: inputs driven on negedge, outputs sampled
// on negedge, expected values hand-computed per cycle.
module tb_timer_sched;
  logic        clk, rst, we, re, rvalid, irq;
  logic [7:0]  addr;
  logic [31:0] wdata, rdata;
  logic [3:0]  irq_id;
  int          n_cmp = 0;
  int          n_bad = 0;

  timer_sched #(.NCH(4), .PRESC_W(16)) dut (
    .clk(clk), .rst(rst), .we(we), .re(re), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rvalid(rvalid), .irq(irq), .irq_id(irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle register write
  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
  endtask

  // One-cycle read; data and valid checked the following negedge
  task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
    re = 1'b1; addr = a;
    @(negedge clk);
    re = 1'b0;
    chk({tag, ".v"}, 32'(rvalid), 32'd1);
    chk(tag, rdata, exp);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; we = 1'b0; re = 1'b0; addr = '0; wdata = '0;
    cyc(3);
    chk("rst.irq", 32'(irq), 0);
    chk("rst.id",  32'(irq_id), 0);
    chk("rst.rv",  32'(rvalid), 0);
    chk("rst.rd",  rdata, 0);
    rst = 1'b0;

    // 1: reset reads, valid pulse, read-during-write, unmapped space
    rd("t1.ctrl", 8'h00, 0);
    rd("t1.pend", 8'h08, 0);
    rd("t1.id",   8'h0C, 0);
    cyc(1);
    chk("t1.rvpulse", 32'(rvalid), 0);
    re = 1'b1; we = 1'b1; addr = 8'h04; wdata = 32'd7;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    chk("t1.rw.v", 32'(rvalid), 1);
    chk("t1.rw.old", rdata, 0);
    rd("t1.presc", 8'h04, 7);
    wr(8'h5C, 32'h55);
    rd("t1.unm", 8'h5C, 0);
    rd("t1.hole", 8'h1C, 0);

    // 2: PRESC=0, CMP0=3 auto-reload with IE; match every 4 ticks
    wr(8'h04, 0);
    wr(8'h10, 3);
    wr(8'h18, 7);
    wr(8'h00, 1);
    cyc(4);
    chk("t2.irq_lag", 32'(irq), 0);
    rd("t2.cnt0", 8'h14, 0);
    chk("t2.irq", 32'(irq), 1);
    chk("t2.id", 32'(irq_id), 1);
    wr(8'h08, 1);
    cyc(1);
    chk("t2.w1c", 32'(irq), 0);
    cyc(1);
    chk("t2.gap", 32'(irq), 0);
    cyc(1);
    chk("t2.rep", 32'(irq), 1);
    wr(8'h18, 0);
    wr(8'h08, 32'hF);

    // 3: PRESC=2, one-shot channel 1
    wr(8'h00, 0);
    wr(8'h04, 2);
    wr(8'h20, 1);
    wr(8'h24, 0);
    wr(8'h28, 5);
    wr(8'h00, 1);
    cyc(6);
    chk("t3.pre", 32'(irq), 0);
    cyc(1);
    chk("t3.irq", 32'(irq), 1);
    chk("t3.id", 32'(irq_id), 2);
    rd("t3.cctl", 8'h28, 4);
    rd("t3.cnt", 8'h24, 1);
    cyc(6);
    rd("t3.hold", 8'h24, 1);
    rd("t3.pend", 8'h08, 2);

    // 4: channels 0 and 2 pending together, priority and IE masking
    wr(8'h00, 0);
    wr(8'h08, 2);
    wr(8'h10, 0);
    wr(8'h14, 0);
    wr(8'h30, 0);
    wr(8'h34, 0);
    wr(8'h18, 5);
    wr(8'h38, 5);
    wr(8'h00, 1);
    cyc(10);
    chk("t4.irq", 32'(irq), 1);
    chk("t4.id01", 32'(irq_id), 1);
    wr(8'h08, 1);
    cyc(1);
    chk("t4.id3", 32'(irq_id), 3);
    wr(8'h38, 0);
    cyc(1);
    chk("t4.mask", 32'(irq), 0);
    chk("t4.maskid", 32'(irq_id), 0);
    rd("t4.pendkept", 8'h08, 4);
    wr(8'h38, 4);
    cyc(1);
    chk("t4.unmask", 32'(irq_id), 3);
    wr(8'h08, 4);
    cyc(1);
    chk("t4.clr", 32'(irq), 0);
    chk("t4.clrid", 32'(irq_id), 0);

    // 5: CNT write in a tick cycle, wrap without event, then match at 5; GEN freeze
    wr(8'h00, 0);
    wr(8'h04, 0);
    wr(8'h10, 5);
    wr(8'h14, 0);
    wr(8'h18, 3);
    wr(8'h08, 32'hF);
    wr(8'h00, 1);
    wr(8'h14, 32'hFFFF_FFFF);
    rd("t5.wrwin", 8'h14, 32'hFFFF_FFFF);
    rd("t5.wrap", 8'h14, 0);
    rd("t5.nopend", 8'h08, 0);
    cyc(4);
    rd("t5.match", 8'h08, 1);
    wr(8'h00, 0);
    rd("t5.frz0", 8'h14, 2);
    cyc(3);
    rd("t5.frz1", 8'h14, 2);
    rd("t5.pendkept", 8'h08, 1);

    // 6: W1C colliding with a match, then reset during a pending irq
    wr(8'h08, 1);
    wr(8'h14, 0);
    wr(8'h00, 1);
    cyc(5);
    wr(8'h08, 1);
    rd("t6.setwins", 8'h08, 1);
    wr(8'h18, 7);
    cyc(1);
    chk("t6.irq", 32'(irq), 1);
    rst = 1'b1; re = 1'b1; addr = 8'h08;
    @(negedge clk);
    re = 1'b0;
    chk("t6.rst.rv", 32'(rvalid), 0);
    chk("t6.rst.rd", rdata, 0);
    chk("t6.rst.irq", 32'(irq), 0);
    chk("t6.rst.id", 32'(irq_id), 0);
    rst = 1'b0;
    rd("t6.ctrl", 8'h00, 0);
    rd("t6.presc", 8'h04, 0);
    rd("t6.pend", 8'h08, 0);
    rd("t6.cctl0", 8'h18, 0);
    rd("t6.cnt0", 8'h14, 0);
    rd("t6.cmp0", 8'h10, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
- Multi-channel timer controller and interrupt scheduler for the SoC.
- Holds NCH independent 32-bit compare timers driven by a shared prescaler, all configured through a simple memory-mapped register port from the CPU bus.
- Latches per-channel match events as pending bits.
- Arbitrates pending channels onto one interrupt line, with a fixed-priority ID: lowest channel index wins.

Parameters:
- NCH, 4, number of timer channels; legal range 1..8.
- PRESC_W, 16, width of the prescaler divisor register.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- we  in  1  register write strobe, single cycle
- re  in  1  register read strobe, single cycle
- addr  in  8  byte address, word aligned; addr[1:0] ignored
- wdata  in  32  write data
- rdata  out  32  read data, registered
- rvalid  out  1  rdata valid, one-cycle pulse
- irq  out  1  interrupt request to CPU, level
- irq_id  out  4  highest-priority pending channel index + 1; 0 = none

Behaviour:
- Reset: all registers 0; rdata=0, rvalid=0, irq=0, irq_id=0; prescaler counter 0.
- Register map:
  - 0x00 CTRL: bit0 GEN, global enable; other bits read 0.
  - 0x04 PRESC: [PRESC_W-1:0], divisor minus 1.
  - 0x08 PEND: [NCH-1:0]; read returns pending bits; write-1-to-clear.
  - 0x0C ID: read-only, equals irq_id.
  - For channel c: 0x10+16c CMP (rw 32); 0x14+16c CNT (rw 32); 0x18+16c CCTL (rw): bit0 EN, bit1 AR (auto-reload), bit2 IE (irq enable).
- Unmapped addresses and channels >= NCH: reads return 0, writes ignored.
- Read latency: re in cycle N gives rdata/rvalid in N+1. re and we in the same cycle: the write occurs and the read returns the pre-write value.
- Prescaler:
  - Counts only while GEN=1.
  - When count==PRESC: tick=1 for that cycle and the count returns to 0; otherwise count+1.
  - GEN=0 holds the count at 0.
  - PRESC=0 gives a tick every cycle.
  - Writing PRESC does not reset the count. If the count is above the new PRESC, it runs to all-ones and wraps to 0 before the next tick.
- Channel on tick, only if EN=1:
  - If CNT==CMP: set PEND[c].
    - AR=1: CNT<=0.
    - AR=0: EN<=0 and CNT holds (one-shot).
  - Otherwise CNT<=CNT+1, wrapping 0xFFFFFFFF->0 without a pending event.
  - CMP=0 matches on the first tick after enable.
- Simultaneous events:
  - A bus write to CNT or CCTL in a tick cycle wins over the tick update for that channel.
  - A PEND set in the same cycle as a W1C of the same bit: set wins, bit remains 1.
- Interrupt outputs:
  - irq and irq_id are registered from (PEND & IE), one cycle after PEND changes.
  - irq = OR of the enabled pending bits; irq_id = lowest set index + 1.
  - Clearing IE masks without clearing PEND.
- GEN=0 freezes all channel counters; PEND and irq are retained.
- rst asserted mid-operation returns everything to reset values on the next clock edge, including pending bits and in-flight rvalid.

Test Plan:
1. Reset then read 0x00, 0x08, 0x0C -> rdata=0 with rvalid one cycle after each re; irq=0.
2. PRESC=0, CMP0=3, CCTL0=0b111, GEN=1 -> PEND[0] set on the 4th tick; irq=1 and irq_id=1 one cycle later; CNT0 returns to 0; event repeats every 4 cycles; W1C 0x08=1 drops irq the cycle after the write.
3. PRESC=2, one-shot channel 1 (CCTL1=0b101) with CMP1=1 -> ticks every 3 cycles; PEND[1] set on the 2nd tick; CCTL1 reads 0b100 afterwards; CNT1 holds at 1.
4. Channels 0 and 2 pending together, both IE=1 -> irq_id=1. Clear PEND[0] -> irq_id=3. Clear PEND[2] -> irq=0, irq_id=0.
5. CNT write in the same cycle as a tick; CNT0=0xFFFFFFFF with CMP0=5 -> the written value persists with no increment in that cycle; the counter wraps to 0 with no PEND, then matches at 5.
6. W1C of PEND[0] in the cycle a match sets it -> PEND[0] stays 1. Assert rst during a pending irq -> irq=0 and all registers read 0 next cycle.
